// File: rtl/counter_arbiter.sv
// Round-robin scheduler sharing one up-counter between Requesters clients.
// The granted client owns the counter for one run from Init to Limit and gets a
// one-cycle Done pulse at the end; dropping its request aborts the run.
module counter_arbiter #(
    parameter int unsigned Requesters = 4,
    parameter int unsigned Width      = 32,
    parameter int unsigned Init       = 8,
    parameter int unsigned Limit      = 64
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic [Requesters-1:0] Req_i,
    output logic [Requesters-1:0] Grant_o,
    output logic [Requesters-1:0] Done_o,
    output logic [Width-1:0]      Data_o,
    output logic                  Busy_o
);

    localparam int unsigned PtrW = $clog2(Requesters);
    localparam logic [Width-1:0] InitVal = Width'(Init);
    localparam logic [Width-1:0] LimitVal = Width'(Limit);
    localparam logic [Requesters-1:0] OneHot = Requesters'(1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Requesters - 1);

    // Refuse to elaborate with an unusable parameter set.
    if ((Requesters < 2) || (Requesters > 16) || !(Init < Limit) ||
        ((Width < 32) && (longint'(Limit) >= (longint'(1) << Width)))) begin : g_bad_params
        $error("counter_arbiter: need 2<=Requesters<=16 and Init < Limit < 2**Width");
    end

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e                  state_q, state_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [PtrW-1:0]         owner_q, owner_d;
    logic [Requesters-1:0]   grant_q, grant_d;
    logic [Requesters-1:0]   done_q, done_d;
    logic [Width-1:0]        data_q, data_d;

    logic                    pick_valid;
    logic [PtrW-1:0]         pick_idx;
    logic [PtrW-1:0]         owner_next;

    // Round-robin search: first requesting client at or above ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic [PtrW-1:0] idx_w;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < Requesters; i++) begin
            idx   = (32'(ptr_q) + i) % Requesters;
            idx_w = PtrW'(idx);
            if (!pick_valid && Req_i[idx_w]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_w;
            end
        end
    end

    // Priority moves to the client just after the one that finished or aborted.
    always_comb begin
        owner_next = (owner_q == LastIdx) ? '0 : owner_q + PtrW'(1);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        done_d  = done_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                done_d  = '0;
                data_d  = InitVal;
                if (pick_valid) begin
                    state_d = StCount;
                    owner_d = pick_idx;
                    grant_d = OneHot << pick_idx;
                end
            end
            StCount: begin
                // Abort wins over both increment and completion.
                if (!Req_i[owner_q]) begin
                    state_d = StIdle;
                    grant_d = '0;
                    data_d  = InitVal;
                    ptr_d   = owner_next;
                end else if (data_q < LimitVal) begin
                    data_d = data_q + Width'(1);
                end else begin
                    state_d = StDone;
                    done_d  = grant_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = '0;
                grant_d = '0;
                data_d  = InitVal;
                ptr_d   = owner_next;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                done_d  = '0;
                data_d  = InitVal;
            end
        endcase
    end

    // State and registered outputs; reset has priority over everything.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            data_q  <= InitVal;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign Grant_o = grant_q;
    assign Done_o  = done_q;
    assign Data_o  = data_q;
    assign Busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: two instances (default and Init=63/Limit=64)
// share one stimulus stream; a behavioural model predicts each cycle's outputs.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [N-1:0] req = '0;

    logic [N-1:0] grant_a, done_a, grant_b, done_b;
    logic [W-1:0] data_a, data_b;
    logic         busy_a, busy_b;

    counter_arbiter #(.Requesters(N), .Width(W), .Init(8), .Limit(64)) u_dut_a (
        .Clk_i   (clk),
        .Reset_i (rst),
        .Req_i   (req),
        .Grant_o (grant_a),
        .Done_o  (done_a),
        .Data_o  (data_a),
        .Busy_o  (busy_a)
    );

    counter_arbiter #(.Requesters(N), .Width(W), .Init(63), .Limit(64)) u_dut_b (
        .Clk_i   (clk),
        .Reset_i (rst),
        .Req_i   (req),
        .Grant_o (grant_b),
        .Done_o  (done_b),
        .Data_o  (data_b),
        .Busy_o  (busy_b)
    );

    // Model: owner = -1 when nobody holds the counter; fin marks the completion cycle.
    typedef struct {
        int owner;
        int ptr;
        int data;
        bit fin;
    } model_t;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic [W-1:0] data;
        logic         busy;
    } exp_t;

    exp_t   qa[$];
    exp_t   qb[$];
    model_t ma, mb;
    int     total = 0;
    int     bad = 0;

    function automatic model_t step(input model_t m, input logic r, input logic [N-1:0] rq,
                                    input int init, input int limit);
        model_t n = m;
        if (r) begin
            n.owner = -1; n.ptr = 0; n.data = init; n.fin = 0;
        end else if (m.fin) begin
            n.ptr = (m.owner + 1) % N; n.owner = -1; n.data = init; n.fin = 0;
        end else if (m.owner < 0) begin
            n.data = init;
            for (int i = 0; i < N; i++) begin
                if (n.owner < 0 && rq[(m.ptr + i) % N]) n.owner = (m.ptr + i) % N;
            end
        end else if (!rq[m.owner]) begin
            n.ptr = (m.owner + 1) % N; n.owner = -1; n.data = init;
        end else if (m.data < limit) begin
            n.data = m.data + 1;
        end else begin
            n.fin = 1;
        end
        return n;
    endfunction

    function automatic exp_t expect_of(input model_t m);
        exp_t         e;
        logic [N-1:0] one = 1;
        e.grant = (m.owner >= 0) ? (one << m.owner) : '0;
        e.done  = m.fin ? e.grant : '0;
        e.data  = W'(m.data);
        e.busy  = (m.owner >= 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUTs must show after the edge.
    task automatic cycle(input logic r, input logic [N-1:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        ma  = step(ma, r, rq, 8, 64);
        mb  = step(mb, r, rq, 63, 64);
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
    endtask

    // Monitor: compare each queued expectation just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_grant", 32'(grant_a), 32'(e.grant));
                chk("a_done", 32'(done_a), 32'(e.done));
                chk("a_data", data_a, e.data);
                chk("a_busy", 32'(busy_a), 32'(e.busy));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_grant", 32'(grant_b), 32'(e.grant));
                chk("b_done", 32'(done_b), 32'(e.done));
                chk("b_data", data_b, e.data);
                chk("b_busy", 32'(busy_b), 32'(e.busy));
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        bit           hit;
        ma = '{owner: -1, ptr: 0, data: 8, fin: 0};
        mb = '{owner: -1, ptr: 0, data: 63, fin: 0};

        // Reset, then idle with no requests.
        cycle(1'b1, '0);
        repeat (6) cycle(1'b0, '0);

        // Single run for client 1 held through completion.
        repeat (62) cycle(1'b0, 4'b0010);

        // Fairness with all clients requesting.
        cycle(1'b1, '0);
        repeat (5 * 59 + 5) cycle(1'b0, 4'b1111);

        // Abort client 2 at data 20, then 4'b1001 must go to client 3.
        cycle(1'b1, '0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle(1'b0, 4'b0100);
            hit = (ma.owner == 2 && ma.data == 20);
        end
        chk("abort_reached", 32'(hit), 32'd1);
        repeat (70) cycle(1'b0, 4'b1001);

        // Reset mid-run at data 40, then 4'b1001 must go to client 0.
        cycle(1'b1, '0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cycle(1'b0, 4'b0110);
            hit = (ma.data == 40);
        end
        chk("reset_reached", 32'(hit), 32'd1);
        cycle(1'b1, 4'b0110);
        repeat (70) cycle(1'b0, 4'b1001);

        // Narrow instance: drop the request exactly at Limit.
        cycle(1'b1, '0);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cycle(1'b0, 4'b0001);
            hit = (mb.owner >= 0 && mb.data == 64);
        end
        chk("limit_reached", 32'(hit), 32'd1);
        repeat (5) cycle(1'b0, '0);

        // Randomised request activity with occasional resets.
        rq = '0;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) rq[$urandom_range(0, N - 1)] ^= 1'b1;
            cycle($urandom_range(0, 999) == 0, rq);
        end

        repeat (3) @(negedge clk);
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
